// File: rtl/fdtd_delay_line.sv
// fdtd_delay_line: multi-channel, valid-qualified delay line that re-aligns
// FDTD field operands whose producing pipelines differ in latency.
// Delay is run-time selectable (0..MAX_DELAY), with stall (en_i) and flush.
// Optional build macro FDTD_DELAY_ZERO_FILL_EN: when defined, data_o is
// forced to zero whenever valid_o is low.

// Per-channel data chain: MAX_DELAY stages plus the tap mux for one channel.
module fdtd_dl_lane #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_DELAY  = 8,
  parameter int DLY_W      = $clog2(MAX_DELAY+1)
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  shift_i,
  input  logic [DLY_W-1:0]      dly_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o
);
  logic [MAX_DELAY-1:0][DATA_WIDTH-1:0] stage_q, stage_d;

  // Next-state: advance the whole chain only on an enabled, non-flush cycle.
  // Flush leaves data untouched; only the shared valid chain is cleared.
  always_comb begin
    stage_d = stage_q;
    if (shift_i) begin
      stage_d[0] = data_i;
      for (int k = 1; k < MAX_DELAY; k++) stage_d[k] = stage_q[k-1];
    end
  end

  // Stage registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) stage_q <= '0;
    else        stage_q <= stage_d;
  end

  // Tap select: delay N reads stage N-1; delay 0 is a combinational bypass.
  always_comb begin
    data_o = data_i;
    for (int k = 0; k < MAX_DELAY; k++)
      if (dly_i == DLY_W'(k+1)) data_o = stage_q[k];
  end
endmodule

module fdtd_delay_line #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 1,
  parameter int MAX_DELAY  = 8,
  parameter int RST_DELAY  = 2,
  parameter int DLY_W      = $clog2(MAX_DELAY+1)
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         en_i,
  input  logic                         flush_i,
  input  logic [DLY_W-1:0]             dly_sel_i,
  input  logic                         valid_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_i,
  output logic                         valid_o,
  output logic [NUM_CH*DATA_WIDTH-1:0] data_o,
  output logic                         busy_o,
  output logic [DLY_W-1:0]             dly_o
);
  logic                                 shift;
  logic [MAX_DELAY-1:0]                 vld_pipe_q, vld_pipe_d;
  logic [DLY_W-1:0]                     dly_q, dly_d, dly_clamp;
  logic                                 upd_ok;
  logic                                 tap_vld, valid_raw;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0]    din_ch, dout_ch;

  assign shift  = en_i & ~flush_i;
  assign din_ch = data_i;

  // Valid chain next-state: flush wins over enable and kills the input too.
  always_comb begin
    vld_pipe_d = vld_pipe_q;
    if (flush_i) begin
      vld_pipe_d = '0;
    end else if (en_i) begin
      vld_pipe_d[0] = valid_i;
      for (int k = 1; k < MAX_DELAY; k++) vld_pipe_d[k] = vld_pipe_q[k-1];
    end
  end

  // Valid chain registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) vld_pipe_q <= '0;
    else        vld_pipe_q <= vld_pipe_d;
  end

  // busy covers every stage, including those past the active tap, so a
  // delay change cannot happen until the whole line has drained.
  assign busy_o = |vld_pipe_q;

  // Delay may only move when the line is empty now and stays empty after
  // this edge; out-of-range requests saturate at the physical depth.
  always_comb begin
    upd_ok    = ~busy_o & ~(|vld_pipe_d);
    dly_clamp = (dly_sel_i > DLY_W'(MAX_DELAY)) ? DLY_W'(MAX_DELAY) : dly_sel_i;
    dly_d     = upd_ok ? dly_clamp : dly_q;
  end

  // Active delay register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) dly_q <= DLY_W'(RST_DELAY);
    else        dly_q <= dly_d;
  end

  assign dly_o = dly_q;

  // Output valid: tap valid masked by en_i so a stalled sample is never
  // presented twice; bypass follows the live input.
  always_comb begin
    tap_vld = 1'b0;
    for (int k = 0; k < MAX_DELAY; k++)
      if (dly_q == DLY_W'(k+1)) tap_vld = vld_pipe_q[k];
    if (dly_q == '0) valid_raw = valid_i & shift;
    else             valid_raw = tap_vld & en_i;
  end

  assign valid_o = valid_raw;

  // One independent data chain per channel; control is shared.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    fdtd_dl_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .MAX_DELAY  (MAX_DELAY),
      .DLY_W      (DLY_W)
    ) u_lane (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .shift_i (shift),
      .dly_i   (dly_q),
      .data_i  (din_ch[c]),
      .data_o  (dout_ch[c])
    );
  end

`ifdef FDTD_DELAY_ZERO_FILL_EN
  // Blank the data bus whenever no valid sample is being presented.
  assign data_o = valid_raw ? dout_ch : '0;
`else
  // Raw tap data regardless of valid.
  assign data_o = dout_ch;
`endif
endmodule

// File: tb/tb_fdtd_delay_line.sv
// Scoreboard bench for fdtd_delay_line: the driver pushes each sample that
// should emerge together with the enabled-edge count at which it is due;
// a negedge monitor pops and compares whenever valid_o is high.
module tb_fdtd_delay_line;
  localparam int DW   = 32;
  localparam int NCH  = 2;
  localparam int MAXD = 8;
  localparam int RSTD = 2;
  localparam int DLYW = $clog2(MAXD+1);
  localparam int BW   = NCH*DW;

  logic            CLK = 1'b0;
  logic            RST_N = 1'b0;
  logic            en_i = 1'b0, flush_i = 1'b0, valid_i = 1'b0;
  logic [DLYW-1:0] dly_sel_i = DLYW'(RSTD);
  logic [BW-1:0]   data_i = '0;
  logic            valid_o, busy_o;
  logic [BW-1:0]   data_o;
  logic [DLYW-1:0] dly_o;

  int checks = 0;
  int errors = 0;
  int en_cnt = 0;

  typedef struct { logic [BW-1:0] data; int due; } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  fdtd_delay_line #(
    .DATA_WIDTH (DW),
    .NUM_CH     (NCH),
    .MAX_DELAY  (MAXD),
    .RST_DELAY  (RSTD)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .en_i      (en_i),
    .flush_i   (flush_i),
    .dly_sel_i (dly_sel_i),
    .valid_i   (valid_i),
    .data_i    (data_i),
    .valid_o   (valid_o),
    .data_o    (data_o),
    .busy_o    (busy_o),
    .dly_o     (dly_o)
  );

  always #5 CLK = ~CLK;

  // Count enabled edges: the time base for latency.
  always @(posedge CLK) if (RST_N && en_i) en_cnt++;

  // Channel 1 carries a distinct pattern so channel swaps are visible.
  function automatic logic [BW-1:0] mk(input logic [31:0] d);
    return {d ^ 32'hFFFF_0000, d};
  endfunction

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle; record the sample if it will enter the line and should exit.
  task automatic drive(input logic en, input logic fl, input logic vl,
                       input logic [31:0] d, input int n, input logic keep);
    en_i = en; flush_i = fl; valid_i = vl; data_i = mk(d);
    if (keep && en && !fl && vl) sb.push_back('{mk(d), en_cnt + n});
    @(posedge CLK); #1;
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 0, 1'b0);
  endtask

  // Bypass cycle with a same-cycle look at the combinational outputs.
  task automatic bypass_chk(input string name, input logic en, input logic fl, input logic vl,
                            input logic [31:0] d, input logic ev, input logic [BW-1:0] ed);
    en_i = en; flush_i = fl; valid_i = vl; data_i = mk(d);
    if (ev) sb.push_back('{mk(d), en_cnt});
    #2;
    chk({name, " valid"}, valid_o, ev);
    chk({name, " data"}, data_o, ed);
    @(posedge CLK); #1;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (busy_o && k < 40) begin idle(); k++; end
    chk(name, busy_o, 0);
  endtask

  // Monitor: every valid_o must match the head of the scoreboard in data and timing.
  always @(negedge CLK) begin
    if (RST_N) begin
      if (valid_o) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid: data_o=%0h at cycle %0d, nothing expected", data_o, en_cnt);
        end else begin
          mon_e = sb.pop_front();
          if (data_o !== mon_e.data || en_cnt != mon_e.due) begin
            errors++;
            $display("FAIL out_sample: got %0h at cycle %0d expected %0h at cycle %0d",
                     data_o, en_cnt, mon_e.data, mon_e.due);
          end
        end
      end
`ifdef FDTD_DELAY_ZERO_FILL_EN
      else begin
        checks++;
        if (data_o !== '0) begin
          errors++;
          $display("FAIL zero_fill: data_o=%0h expected 0", data_o);
        end
      end
`endif
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values
    #12;
    chk("rst valid_o", valid_o, 0);
    chk("rst busy_o", busy_o, 0);
    chk("rst dly_o", dly_o, RSTD);
    chk("rst data_o", data_o, 0);
    @(posedge CLK); #1;
    RST_N = 1'b1;

    // 1: default delay 2
    drive(1, 0, 1, 32'h11, 2, 1);
    drive(1, 0, 1, 32'h22, 2, 1);
    drive(1, 0, 1, 32'h33, 2, 1);
    drain("t1 drain");

    // 2: delay 5
    dly_sel_i = 4'd5;
    idle();
    chk("t2 dly_o", dly_o, 5);
    for (int i = 0; i < 4; i++) drive(1, 0, 1, 32'hA0 + i, 5, 1);
    drain("t2 drain");

    // 3: stall, including a stall while the sample sits at the tap
    dly_sel_i = 4'd3;
    idle();
    chk("t3 dly_o", dly_o, 3);
    drive(1, 0, 1, 32'hB1, 3, 1);
    idle();
    drive(0, 0, 1, 32'hEE, 3, 1);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 32'h0, 3, 0);
    idle();
    drive(0, 0, 0, 32'h0, 3, 0);
    drain("t3 drain");

    // 4: flush kills in-flight and same-cycle samples
    dly_sel_i = 4'd4;
    idle();
    chk("t4 dly_o", dly_o, 4);
    drive(1, 0, 1, 32'hC1, 4, 0);
    drive(1, 0, 1, 32'hC2, 4, 0);
    drive(1, 1, 1, 32'hCC, 4, 0);
    chk("t4 busy after flush", busy_o, 0);
    for (int i = 0; i < 6; i++) idle();

    // 5: delay request while busy is deferred until drained
    for (int i = 0; i < 6; i++) begin
      if (i == 2) dly_sel_i = 4'd1;
      drive(1, 0, 1, 32'hD0 + i, 4, 1);
    end
    chk("t5 dly held busy", dly_o, 4);
    drain("t5 drain");
    chk("t5 dly at busy fall", dly_o, 4);
    idle();
    chk("t5 dly after drain", dly_o, 1);

    // 6: bypass, then clamp
    dly_sel_i = 4'd0;
    idle();
    chk("t6 dly_o bypass", dly_o, 0);
    bypass_chk("t6 byp v1", 1, 0, 1, 32'h5A, 1, mk(32'h5A));
`ifdef FDTD_DELAY_ZERO_FILL_EN
    bypass_chk("t6 byp v0", 1, 0, 0, 32'h77, 0, '0);
    bypass_chk("t6 byp stall", 0, 0, 1, 32'h66, 0, '0);
    bypass_chk("t6 byp flush", 1, 1, 1, 32'h55, 0, '0);
`else
    bypass_chk("t6 byp v0", 1, 0, 0, 32'h77, 0, mk(32'h77));
    bypass_chk("t6 byp stall", 0, 0, 1, 32'h66, 0, mk(32'h66));
    bypass_chk("t6 byp flush", 1, 1, 1, 32'h55, 0, mk(32'h55));
`endif
    drain("t6 drain bypass");
    dly_sel_i = 4'd15;
    idle();
    chk("t6 dly_o clamp", dly_o, MAXD);
    drive(1, 0, 1, 32'hF8, 8, 1);
    drain("t6 drain max");

    // 7: reset mid-stream discards everything
    drive(1, 0, 1, 32'h71, 8, 0);
    drive(1, 0, 1, 32'h72, 8, 0);
    #2;
    RST_N = 1'b0;
    #1;
    chk("t7 rst valid_o", valid_o, 0);
    chk("t7 rst busy_o", busy_o, 0);
    chk("t7 rst dly_o", dly_o, RSTD);
    chk("t7 rst data_o", data_o, 0);
    valid_i = 1'b0;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    for (int i = 0; i < 10; i++) idle();
    chk("sb empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fdtd_delay_line.md
Name: fdtd_delay_line

Overview:
Parametrised, multi-channel, valid-qualified delay line for the FDTD datapath. It aligns field operands whose pipelines differ in latency.
- Delay is selectable at run time, from 0 to MAX_DELAY cycles.
- Supports a global stall (en_i) and a flush.
- Sits between FDTD update stages, wherever operand skew must be matched.

Parameters:
- DATA_WIDTH, 32, bits per channel.
- NUM_CH, 1, number of parallel channels; all channels share one valid and one delay setting.
- MAX_DELAY, 8, number of physical stages and maximum selectable delay (must be >= 1).
- RST_DELAY, 2, delay value loaded at reset (must be <= MAX_DELAY).
- DLY_W, $clog2(MAX_DELAY+1), width of the delay-select field (derived; do not override).

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- en_i  in  1  advance enable; 0 freezes every stage (stall).
- flush_i  in  1  invalidates all in-flight data.
- dly_sel_i  in  DLY_W  requested delay in cycles.
- valid_i  in  1  input sample valid.
- data_i  in  NUM_CH*DATA_WIDTH  input data; channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
- valid_o  out  1  output sample valid.
- data_o  out  NUM_CH*DATA_WIDTH  delayed data, same packing as data_i.
- busy_o  out  1  1 while any stage holds a valid sample.
- dly_o  out  DLY_W  delay currently in effect (dly_q).

Behaviour:
- Storage: MAX_DELAY stages, each holding NUM_CH*DATA_WIDTH data bits plus one valid bit (v[k]).
- Reset (RST_N=0, asynchronous): all data and valid bits = 0; dly_q = RST_DELAY.
  - Resulting outputs: valid_o=0, busy_o=0, dly_o=RST_DELAY, data_o=0.
  - Reset mid-stream discards all in-flight samples; nothing is emitted after release until new input arrives.
- Shift, when en_i=1 and flush_i=0, on each rising edge:
  - stage0 <= {valid_i, data_i};
  - stage k <= stage k-1 for k = 1..MAX_DELAY-1.
- Stall, when en_i=0 and flush_i=0: all stages hold; valid_i and data_i are ignored.
- Flush, when flush_i=1:
  - next edge clears every v[k]; data bits are unchanged.
  - Input presented in the same cycle is discarded.
  - flush_i has priority over en_i.
- Output mux when dly_q = N, N >= 1:
  - valid_o = v[N-1] & en_i.
  - data_o = stage N-1 data.
  - Latency is N enabled cycles; stall cycles do not count. valid_o is masked during a stall so the consumer never double-counts a sample.
- Output when dly_q = 0 (combinational bypass): valid_o = valid_i & en_i & ~flush_i; data_o = data_i.
- Delay update:
  - dly_q <= dly_sel_i only on an edge where busy_o=0 and the update cycle's own shift leaves every stage invalid; otherwise dly_q holds.
  - Consequence: a new delay takes effect only after the line drains, so samples are never duplicated or dropped.
  - If dly_sel_i > MAX_DELAY, dly_q loads MAX_DELAY (clamp).
- busy_o = OR of all v[k], k = 0..MAX_DELAY-1; a registered OR is not permitted.
- Stages at index >= dly_q still shift. Their valid bits keep busy_o=1 until they shift out, which guarantees a clean drain before any delay change.
- Channels share control; each channel's bits are moved independently, with no cross-channel arithmetic.
- Throughput: one sample per enabled cycle; no backpressure beyond en_i.

Optional Feature:
- Macro: FDTD_DELAY_ZERO_FILL_EN.
- Defined: data_o is forced to all-zero whenever valid_o=0, including stall cycles and bypass mode with valid_i=0.
- Not defined: data_o always shows the raw selected-stage data (or data_i in bypass), regardless of valid_o.
- valid_o, busy_o and dly_o are identical in both builds.

Test Plan:
1. Reset, then valid_i=1 with data 0x11, 0x22, 0x33 on three consecutive enabled cycles, RST_DELAY=2 -> valid_o=1 with data_o 0x11, 0x22, 0x33 on cycles 2, 3, 4 after the first input edge.
2. dly_sel_i=5 while idle; stream 0xA0..0xA3 -> dly_o=5; each sample appears exactly 5 enabled cycles after its input.
3. Stall: dly=3; input 0xB1; en_i=0 for 4 cycles after 1 shift -> valid_o stays 0 during the stall; 0xB1 emerges after 2 further enabled cycles (3 enabled cycles in total).
4. Flush: dly=4; two samples in flight; flush_i=1 for 1 cycle with valid_i=1 and data 0xCC -> no valid_o ever for those samples or for 0xCC; busy_o=0 the next cycle.
5. Delay change while busy: dly=4, stream 6 samples, set dly_sel_i=1 mid-stream -> all 6 samples exit at delay 4; dly_o changes to 1 only after busy_o falls.
6. Bypass and clamp: dly_sel_i=0 -> data_o = data_i in the same cycle and valid_o = valid_i; then dly_sel_i=15 with MAX_DELAY=8 -> dly_o=8. With FDTD_DELAY_ZERO_FILL_EN defined, also check data_o=0 whenever valid_o=0.
